// File: rtl/z80_io_pkg.sv
// Shared port codes and default ROM bank values for the Z80 I/O decoder.
package z80_io_pkg;

  localparam logic [4:0] PORT_CMD       = 5'h00;
  localparam logic [4:0] PORT_YM        = 5'h04;
  localparam logic [4:0] PORT_YM_MASK   = 5'h1C;
  localparam logic [4:0] PORT_NMI_EN    = 5'h08;
  localparam logic [4:0] PORT_NMI_DIS   = 5'h18;
  localparam logic [4:0] PORT_BANK_BASE = 5'h08;
  localparam logic [4:0] PORT_REPLY     = 5'h0C;

  localparam logic [7:0] BANK0_DEF = 8'h1E;
  localparam logic [7:0] BANK1_DEF = 8'h0E;
  localparam logic [7:0] BANK2_DEF = 8'h06;
  localparam logic [7:0] BANK3_DEF = 8'h02;

  // Bank ports occupy 0x08..0x0B; the low two bits select the bank.
  function automatic logic is_bank_port(input logic [4:0] port);
    return (port & 5'h1C) == PORT_BANK_BASE;
  endfunction

endpackage

// File: rtl/z80_io_ctrl_edge_det.sv
// Registered single-edge detector; the history register resets to RST_VAL so
// releasing reset never produces a spurious edge.
module edge_det #(
  parameter logic RISE    = 1'b1,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic edge_o
);

  logic d_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) d_q <= RST_VAL;
    else       d_q <= d_i;
  end

  assign edge_o = RISE ? (d_i & ~d_q) : (~d_i & d_q);

endmodule

// File: rtl/z80_io_ctrl.sv
// Z80-side I/O decode for the NeoGeo sound CPU: latch strobes, YM2610 select,
// ROM bank registers and NMI generation from the 68k command write.
module z80_io_ctrl
  import z80_io_pkg::*;
#(
  parameter logic [7:0] BANK0_RST = BANK0_DEF,
  parameter logic [7:0] BANK1_RST = BANK1_DEF,
  parameter logic [7:0] BANK2_RST = BANK2_DEF,
  parameter logic [7:0] BANK3_RST = BANK3_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] SDA,
  input  logic        nIORQ,
  input  logic        nRD,
  input  logic        nWR,
  input  logic        nM1,
  input  logic        nSDW,
  output logic        nSDZ80R,
  output logic        nSDZ80W,
  output logic        nSDZ80CLR,
  output logic        nZ80NMI,
  output logic        YM_CS,
  output logic [1:0]  YM_A,
  output logic [7:0]  BANK0,
  output logic [7:0]  BANK1,
  output logic [7:0]  BANK2,
  output logic [7:0]  BANK3
);

  logic [4:0] port;
  logic       io_rd, io_wr;
  logic       dec_cmd_rd, dec_cmd_clr, dec_reply, dec_ym;
  logic       dec_nmi_en, dec_nmi_dis, dec_bank;
  logic       sdw_rise, cmd_rd_rise, nmi_en_rise, nmi_dis_rise, bank_rise;
  logic       unused_sda_mirror;

  logic       nsdz80r_q, nsdz80w_q, nsdz80clr_q, nz80nmi_q, ym_cs_q;
  logic [1:0] ym_a_q;
  logic       nmi_en_q, nmi_en_d;
  logic       nmi_pend_q, nmi_pend_d;
  logic [3:0][7:0] bank_q, bank_d;

  assign port  = SDA[4:0];
  assign io_rd = ~nIORQ & ~nRD & nM1;
  assign io_wr = ~nIORQ & ~nWR & nM1;
  assign unused_sda_mirror = ^SDA[7:5];

  assign dec_cmd_rd  = io_rd & (port == PORT_CMD);
  assign dec_cmd_clr = io_wr & (port == PORT_CMD);
  assign dec_reply   = io_wr & (port == PORT_REPLY);
  assign dec_ym      = (io_rd | io_wr) & ((port & PORT_YM_MASK) == PORT_YM);
  assign dec_nmi_en  = io_wr & (port == PORT_NMI_EN);
  assign dec_nmi_dis = io_wr & (port == PORT_NMI_DIS);
  assign dec_bank    = io_rd & is_bank_port(port);

  // nSDW idles high; its rising edge marks the end of the 68k command write.
  edge_det #(.RISE(1'b1), .RST_VAL(1'b1)) u_sdw (
    .clk_i(CLK), .rst_i(RESET), .d_i(nSDW), .edge_o(sdw_rise)
  );
  edge_det #(.RISE(1'b1), .RST_VAL(1'b0)) u_cmd_rd (
    .clk_i(CLK), .rst_i(RESET), .d_i(dec_cmd_rd), .edge_o(cmd_rd_rise)
  );
  edge_det #(.RISE(1'b1), .RST_VAL(1'b0)) u_nmi_en (
    .clk_i(CLK), .rst_i(RESET), .d_i(dec_nmi_en), .edge_o(nmi_en_rise)
  );
  edge_det #(.RISE(1'b1), .RST_VAL(1'b0)) u_nmi_dis (
    .clk_i(CLK), .rst_i(RESET), .d_i(dec_nmi_dis), .edge_o(nmi_dis_rise)
  );
  edge_det #(.RISE(1'b1), .RST_VAL(1'b0)) u_bank (
    .clk_i(CLK), .rst_i(RESET), .d_i(dec_bank), .edge_o(bank_rise)
  );

  always_comb begin
    nmi_en_d   = nmi_en_q;
    nmi_pend_d = nmi_pend_q;
    bank_d     = bank_q;
    if (nmi_en_rise)       nmi_en_d = 1'b1;
    else if (nmi_dis_rise) nmi_en_d = 1'b0;
    // A new command arriving while the old one is read back must not be lost.
    if (sdw_rise)          nmi_pend_d = 1'b1;
    else if (cmd_rd_rise)  nmi_pend_d = 1'b0;
    if (bank_rise)         bank_d[port[1:0]] = SDA[15:8];
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      nsdz80r_q   <= 1'b1;
      nsdz80w_q   <= 1'b1;
      nsdz80clr_q <= 1'b1;
      nz80nmi_q   <= 1'b1;
      ym_cs_q     <= 1'b0;
      ym_a_q      <= 2'b00;
      nmi_en_q    <= 1'b0;
      nmi_pend_q  <= 1'b0;
      bank_q      <= {BANK3_RST, BANK2_RST, BANK1_RST, BANK0_RST};
    end else begin
      nsdz80r_q   <= ~dec_cmd_rd;
      nsdz80w_q   <= ~dec_reply;
      nsdz80clr_q <= ~dec_cmd_clr;
      nz80nmi_q   <= ~(nmi_pend_q & nmi_en_q);
      ym_cs_q     <= dec_ym;
      ym_a_q      <= SDA[1:0];
      nmi_en_q    <= nmi_en_d;
      nmi_pend_q  <= nmi_pend_d;
      bank_q      <= bank_d;
    end
  end

  assign nSDZ80R   = nsdz80r_q;
  assign nSDZ80W   = nsdz80w_q;
  assign nSDZ80CLR = nsdz80clr_q;
  assign nZ80NMI   = nz80nmi_q;
  assign YM_CS     = ym_cs_q;
  assign YM_A      = ym_a_q;
  assign BANK0     = bank_q[0];
  assign BANK1     = bank_q[1];
  assign BANK2     = bank_q[2];
  assign BANK3     = bank_q[3];

endmodule

// File: tb/tb_z80_io_ctrl.sv
// Scoreboard bench for z80_io_ctrl: a cycle-level reference model pushes the
// expected outputs after every clock, an independent monitor compares them.
module tb_z80_io_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] SDA;
  logic        nIORQ, nRD, nWR, nM1, nSDW;
  logic        nSDZ80R, nSDZ80W, nSDZ80CLR, nZ80NMI, YM_CS;
  logic [1:0]  YM_A;
  logic [7:0]  BANK0, BANK1, BANK2, BANK3;

  z80_io_ctrl dut (
    .CLK(CLK), .RESET(RESET), .SDA(SDA), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR),
    .nM1(nM1), .nSDW(nSDW), .nSDZ80R(nSDZ80R), .nSDZ80W(nSDZ80W),
    .nSDZ80CLR(nSDZ80CLR), .nZ80NMI(nZ80NMI), .YM_CS(YM_CS), .YM_A(YM_A),
    .BANK0(BANK0), .BANK1(BANK1), .BANK2(BANK2), .BANK3(BANK3)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [38:0] exp_q[$];

  // Reference model state: what the Z80 program has configured, plus the
  // previous cycle's view of each one-shot event so "first cycle" is known.
  logic       m_en, m_pend;
  logic       m_prev_nsdw, m_prev_cmd, m_prev_en, m_prev_dis, m_prev_bank;
  logic [7:0] m_bank[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_en = 0; m_pend = 0;
    m_prev_nsdw = 1; m_prev_cmd = 0; m_prev_en = 0; m_prev_dis = 0; m_prev_bank = 0;
    m_bank[0] = 8'h1E; m_bank[1] = 8'h0E; m_bank[2] = 8'h06; m_bank[3] = 8'h02;
  endfunction

  // Called right after a rising edge with the inputs that edge sampled.
  function automatic void model_step();
    logic rd, wr, cmd_rd, bank_rd, en_wr, dis_wr, nmi_out;
    int p;
    if (RESET) begin
      model_reset();
      exp_q.push_back({1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00,
                       8'h1E, 8'h0E, 8'h06, 8'h02});
      return;
    end
    rd = !nIORQ && !nRD && nM1;
    wr = !nIORQ && !nWR && nM1;
    p  = int'(SDA[4:0]);
    cmd_rd  = rd && p == 0;
    bank_rd = rd && p >= 8 && p <= 11;
    en_wr   = wr && p == 8;
    dis_wr  = wr && p == 24;
    nmi_out = !(m_pend && m_en);
    if (en_wr && !m_prev_en)   m_en = 1;
    if (dis_wr && !m_prev_dis) m_en = 0;
    if (nSDW && !m_prev_nsdw)      m_pend = 1;
    else if (cmd_rd && !m_prev_cmd) m_pend = 0;
    if (bank_rd && !m_prev_bank) m_bank[p - 8] = SDA[15:8];
    m_prev_nsdw = nSDW; m_prev_cmd = cmd_rd; m_prev_en = en_wr;
    m_prev_dis = dis_wr; m_prev_bank = bank_rd;
    exp_q.push_back({!cmd_rd, !(wr && p == 12), !(wr && p == 0), nmi_out,
                     (rd || wr) && p >= 4 && p <= 7, SDA[1:0],
                     m_bank[0], m_bank[1], m_bank[2], m_bank[3]});
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      model_step();
      #1;
    end
  endtask

  task automatic idle();
    nIORQ = 1; nRD = 1; nWR = 1; nM1 = 1;
  endtask

  task automatic io(input logic wr, input logic [15:0] a, input int n);
    SDA = a; nM1 = 1; nIORQ = 0;
    if (wr) nWR = 0; else nRD = 0;
    tick(n);
    idle();
    tick(1);
  endtask

  // Monitor: outputs are valid every cycle; compare on the falling edge.
  initial begin
    logic [38:0] e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("strobes_nmi_ya", {25'd0, nSDZ80R, nSDZ80W, nSDZ80CLR, nZ80NMI, YM_CS, YM_A},
            {25'd0, e[38:32]});
        chk("banks", {BANK0, BANK1, BANK2, BANK3}, e[31:0]);
      end
    end
  end

  initial begin
    int hold;
    logic [4:0] ports[12];
    ports = '{5'h00, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A,
              5'h0B, 5'h0C, 5'h18, 5'h13};
    model_reset();
    RESET = 1; SDA = 16'h0000; nSDW = 1; idle();
    tick(2);
    RESET = 0;
    tick(2);
    @(negedge CLK);
    chk("rst_bank0", BANK0, 8'h1E);
    chk("rst_bank3", BANK3, 8'h02);
    chk("rst_nmi", nZ80NMI, 1);
    chk("rst_ymcs", YM_CS, 0);

    // Enable NMI, deliver a command, read it back.
    io(1, 16'h0008, 2);
    nSDW = 0; tick(3);
    nSDW = 1; tick(2);
    @(negedge CLK);
    chk("nmi_after_cmd", nZ80NMI, 0);
    SDA = 16'h0000; nIORQ = 0; nRD = 0;
    tick(1);
    @(negedge CLK);
    chk("cmd_read_strobe", nSDZ80R, 0);
    tick(2); idle(); tick(1);
    @(negedge CLK);
    chk("nmi_cleared", nZ80NMI, 1);

    // Command while disabled, then enable/disable with pending kept.
    io(1, 16'h0018, 1);
    nSDW = 0; tick(2);
    nSDW = 1; tick(3);
    @(negedge CLK);
    chk("nmi_disabled", nZ80NMI, 1);
    io(1, 16'h0008, 1);
    @(negedge CLK);
    chk("nmi_reenabled", nZ80NMI, 0);
    io(1, 16'h0018, 1);
    @(negedge CLK);
    chk("nmi_masked", nZ80NMI, 1);
    io(1, 16'h0008, 1);
    @(negedge CLK);
    chk("nmi_pending_kept", nZ80NMI, 0);

    // Bank loads, one held access.
    io(0, 16'h3A0B, 5);
    io(0, 16'h070A, 1);
    @(negedge CLK);
    chk("bank3_load", BANK3, 8'h3A);
    chk("bank2_load", BANK2, 8'h07);
    chk("bank1_kept", BANK1, 8'h0E);

    // Reply write, clear, YM mirror.
    io(1, 16'h000C, 2);
    io(1, 16'h0000, 2);
    SDA = 16'h0085; nIORQ = 0; nWR = 0;
    tick(1);
    @(negedge CLK);
    chk("ym_cs_mirror", YM_CS, 1);
    chk("ym_a_mirror", YM_A, 2'b01);
    idle(); tick(1);

    // Interrupt acknowledge decodes nothing.
    SDA = 16'h0000; nIORQ = 0; nM1 = 0;
    tick(3);
    @(negedge CLK);
    chk("iack_no_rd", nSDZ80R, 1);
    chk("iack_no_clr", nSDZ80CLR, 1);
    idle(); tick(1);

    // Clear pending, then command end coinciding with the first read cycle.
    io(0, 16'h0000, 1);
    tick(2);
    nSDW = 0; tick(2);
    nSDW = 1; SDA = 16'h0000; nIORQ = 0; nRD = 0;
    tick(2); idle(); tick(2);
    @(negedge CLK);
    chk("set_wins_clear", nZ80NMI, 0);

    // Reset in the middle of a held bank read, then a fresh first cycle.
    SDA = 16'h550B; nIORQ = 0; nRD = 0;
    tick(2);
    @(negedge CLK);
    #1 RESET = 1;
    #1 chk("async_reset_bank3", BANK3, 8'h02);
    chk("async_reset_rd", nSDZ80R, 1);
    tick(1);
    RESET = 0;
    tick(2);
    @(negedge CLK);
    chk("reload_after_reset", BANK3, 8'h55);
    idle(); tick(1);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      SDA   = {$urandom_range(255, 0) & 8'hFF, 3'($urandom_range(7, 0)),
               ports[$urandom_range(11, 0)]};
      nIORQ = ($urandom_range(3, 0) == 0);
      nRD   = $urandom_range(1, 0) == 1;
      nWR   = nRD ? ($urandom_range(1, 0) == 1) : 1'b1;
      nM1   = ($urandom_range(7, 0) != 0);
      if ($urandom_range(5, 0) == 0) nSDW = ~nSDW;
      hold = $urandom_range(4, 1);
      tick(hold);
    end

    idle(); nSDW = 1;
    tick(2);
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge CLK);
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/z80_io_ctrl.md
Name: z80_io_ctrl

Overview:
- Z80-side I/O decoder and sound-CPU control for the NeoGeo audio subsystem.
- Sits between the Z80 bus and the 68k/Z80 command/reply latch block.
  - Generates that block's nSDZ80R, nSDZ80W and nSDZ80CLR strobes.
  - Consumes its nSDW output to raise the Z80 NMI.
- Also holds the four Z80 ROM bank registers and decodes YM2610 chip selects.

Parameters:
- BANK0_RST, 8'h1E, reset bank for the 2 KB window F000-F7FF.
- BANK1_RST, 8'h0E, reset bank for the 4 KB window E000-EFFF.
- BANK2_RST, 8'h06, reset bank for the 8 KB window C000-DFFF.
- BANK3_RST, 8'h02, reset bank for the 16 KB window 8000-BFFF.

Ports:
- CLK  in  1  system clock; all state on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- SDA  in  16  Z80 address bus.
- nIORQ  in  1  Z80 I/O request, active low.
- nRD  in  1  Z80 read strobe, active low.
- nWR  in  1  Z80 write strobe, active low.
- nM1  in  1  Z80 M1, active low; nIORQ&nM1 low together is an interrupt acknowledge.
- nSDW  in  1  from the command latch; low while the 68k writes REG_SOUND.
- nSDZ80R  out  1  command-port read strobe, active low.
- nSDZ80W  out  1  reply-port write strobe, active low; the latch captures on its rising edge.
- nSDZ80CLR  out  1  command clear strobe, active low; the latch acts on its falling edge.
- nZ80NMI  out  1  Z80 NMI, active low.
- YM_CS  out  1  YM2610 access, active high.
- YM_A  out  2  YM2610 register address, equal to SDA[1:0].
- BANK0, BANK1, BANK2, BANK3  out  8 each  ROM bank registers.

Behaviour:
- Access definition: IO_RD = ~nIORQ & ~nRD & nM1; IO_WR = ~nIORQ & ~nWR & nM1. Interrupt acknowledge (nM1 low) decodes nothing.
- Port decode uses SDA[4:0]; SDA[7:5] are don't-care (mirrors).
  - Read 0x00: nSDZ80R.
  - Write 0x00: nSDZ80CLR.
  - 0x04-0x07, read or write: YM_CS.
  - Write 0x08: NMI enable.
  - Write 0x18: NMI disable.
  - Read 0x08/0x09/0x0A/0x0B: load BANK0/1/2/3 with SDA[15:8].
  - Write 0x0C: nSDZ80W.
  - All other ports: no effect.
- Strobes (nSDZ80R, nSDZ80W, nSDZ80CLR, YM_CS) are registered.
  - Each asserts 1 CLK after the qualifying access condition is first sampled.
  - Each deasserts 1 CLK after the condition drops.
  - They are glitch-free level strobes for the whole access, with no combinational path from input to output.
- Bank load happens once per access, on the first CLK where the read condition is true (rising-edge detect of the decode). A held read does not reload.
- NMI enable/disable act once per access, on the first cycle of the write.
- NMI logic:
  - nmi_pending is set on the rising edge of nSDW (end of the 68k command write), using a registered nSDW edge detect.
  - nmi_pending is cleared on the first cycle of a port-0x00 read.
  - nZ80NMI = ~(nmi_pending & nmi_en), registered.
  - Disabling NMI while pending: nZ80NMI goes high, but pending is kept. Re-enabling reasserts nZ80NMI without a new command.
- Simultaneous events:
  - nSDW rising edge in the same cycle as the port-0 read clear: set wins, pending stays 1.
  - Enable and disable cannot coincide (distinct ports).
- Reset values:
  - All strobes inactive: nSDZ80R=1, nSDZ80W=1, nSDZ80CLR=1, YM_CS=0.
  - nZ80NMI=1, nmi_en=0, nmi_pending=0.
  - BANKn=BANKn_RST.
  - Internal edge-detect registers reset to the inactive level (nSDW_d=1, decode_d=0), so no edge is produced on reset release.
- Reset asserted mid-access: everything returns to reset values immediately. After release, an access still in progress is treated as a fresh first cycle.

Decomposition:
- Shared package z80_io_pkg holds:
  - port codes PORT_CMD=5'h00, PORT_YM=5'h04 (mask 5'h1C), PORT_NMI_EN=5'h08, PORT_NMI_DIS=5'h18, PORT_BANK_BASE=5'h08, PORT_REPLY=5'h0C;
  - default bank constants.
- One sub-module: edge_det, a 1-bit registered rise/fall detector with async reset and a reset-level parameter. It is instanced for nSDW and for each one-shot decode.

Test Plan:
- Reset release: no access -> BANK0..3 = 1E/0E/06/02, nZ80NMI=1, all strobes inactive, YM_CS=0.
- Write port 0x08, then pulse nSDW low for 3 cycles -> nZ80NMI=0 two CLK after the nSDW rise. Read port 0x00 -> nSDZ80R low during the access, nZ80NMI=1 next cycle.
- With NMI disabled, pulse nSDW -> nZ80NMI stays 1. Then write port 0x08 -> nZ80NMI=0. Then write port 0x18 -> nZ80NMI=1, pending still set.
- Read with SDA=16'h3A0B held 5 cycles -> BANK3=8'h3A loaded once. Read SDA=16'h070A -> BANK2=8'h07. BANK0/1 unchanged.
- Write port 0x0C, then 0x00, then 0x85 (mirror of 0x05) -> nSDZ80W low then high, then nSDZ80CLR low, then YM_CS=1 with YM_A=2'b01. Each strobe lags the access by 1 CLK.
- Interrupt acknowledge (nM1=0, nIORQ=0, SDA=0x0000) -> no strobe. nSDW rise coinciding with the first cycle of a port-0 read -> nmi_pending remains 1.
